// File: rtl/rice_pkg.sv
// Shared types and constants for the Rice CDS sequencer: FSM states,
// header-length thresholds and datapath widths.
package rice_pkg;

    localparam int WORD_W = 32;
    localparam int ID_W   = 5;
    localparam int CNT_W  = 16;
    localparam int LEN_W  = 3;
    localparam int CFG_W  = 5;

    // Upper bounds of cfg_n for header lengths 2, 3 and 4; above the last one the length is 5.
    localparam logic [CFG_W-1:0] HDR_N_T0 = 5'd4;
    localparam logic [CFG_W-1:0] HDR_N_T1 = 5'd8;
    localparam logic [CFG_W-1:0] HDR_N_T2 = 5'd16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRI  = 2'd1,
        ID   = 2'd2,
        BODY = 2'd3
    } state_e;

endpackage

// File: rtl/rice_hdr_len_lut.sv
// Maps the sample resolution cfg_n to the CDS option-ID header length.
module rice_hdr_len_lut
    import rice_pkg::*;
(
    input  logic [CFG_W-1:0] cfg_n,
    output logic [LEN_W-1:0] hdr_len
);

    always_comb begin
        if (cfg_n <= HDR_N_T0)      hdr_len = 3'd2;
        else if (cfg_n <= HDR_N_T1) hdr_len = 3'd3;
        else if (cfg_n <= HDR_N_T2) hdr_len = 3'd4;
        else                        hdr_len = 3'd5;
    end

endmodule

// File: rtl/rice_cds_sequencer.sv
// Splits a packet word stream into CDS units for a Rice decoder: drops the
// primary header, strips the option-ID header from each CDS and counts CDSs.
module rice_cds_sequencer
    import rice_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [CFG_W-1:0]  cfg_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_last,
    output logic              d_valid,
    input  logic              d_ready,
    output logic [WORD_W-1:0] d_data,
    output logic              d_first,
    input  logic              dec_done,
    output logic              hdr_valid,
    output logic [ID_W-1:0]   hdr_id,
    output logic [LEN_W-1:0]  hdr_len,
    output logic              busy,
    output logic              err_trunc,
    output logic [CNT_W-1:0]  cds_count
);

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   hdr_len_q, hdr_len_d;
    logic [ID_W-1:0]    hdr_id_q, hdr_id_d;
    logic [CNT_W-1:0]   cds_count_q, cds_count_d;
    logic               last_seen_q, last_seen_d;
    logic               hdr_valid_q, hdr_valid_d;
    logic               err_trunc_q, err_trunc_d;
    logic [LEN_W-1:0]   lut_len;
    logic               s_xfer;
    logic [5:0]         id_sh;
    logic [WORD_W-1:0]  id_shr;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    rice_hdr_len_lut u_len_lut (
        .cfg_n   (cfg_n),
        .hdr_len (lut_len)
    );

    assign s_xfer = s_valid && s_ready;
    assign id_sh  = 6'd32 - {3'b000, hdr_len_q};
    assign id_shr = s_data >> id_sh;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (s_valid) state_d = PRI;
            PRI:  if (s_xfer) state_d = s_last ? IDLE : ID;
            ID:   if (s_xfer) state_d = s_last ? IDLE : BODY;
            BODY: if (dec_done) state_d = (last_seen_q || (s_xfer && s_last)) ? IDLE : ID;
            default: state_d = IDLE;
        endcase
    end

    // Once the packet's last word has been taken, BODY stalls both sides until the decoder finishes.
    always_comb begin
        s_ready = 1'b0;
        d_valid = 1'b0;
        d_first = 1'b0;
        d_data  = '0;
        busy    = (state_q != IDLE);
        case (state_q)
            PRI:  s_ready = 1'b1;
            ID: begin
                d_valid = s_valid;
                s_ready = d_ready;
                d_first = 1'b1;
                d_data  = s_data << hdr_len_q;
            end
            BODY: begin
                d_valid = s_valid && !last_seen_q;
                s_ready = d_ready && !last_seen_q;
                d_data  = s_data;
            end
            default: ;
        endcase
    end

    always_comb begin
        hdr_len_d   = hdr_len_q;
        hdr_id_d    = hdr_id_q;
        cds_count_d = cds_count_q;
        last_seen_d = last_seen_q;
        hdr_valid_d = 1'b0;
        err_trunc_d = 1'b0;
        case (state_q)
            IDLE: if (s_valid) begin
                hdr_len_d   = lut_len;
                cds_count_d = '0;
                last_seen_d = 1'b0;
            end
            PRI: if (s_xfer && s_last) err_trunc_d = 1'b1;
            ID: if (s_xfer) begin
                if (s_last) begin
                    err_trunc_d = 1'b1;
                end else begin
                    hdr_id_d    = id_shr[ID_W-1:0];
                    hdr_valid_d = 1'b1;
                end
            end
            BODY: begin
                if (s_xfer && s_last) last_seen_d = 1'b1;
                if (dec_done) begin
                    cds_count_d = sat_inc(cds_count_q);
                    if (state_d == IDLE) last_seen_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hdr_len_q   <= '0;
            hdr_id_q    <= '0;
            cds_count_q <= '0;
            last_seen_q <= 1'b0;
            hdr_valid_q <= 1'b0;
            err_trunc_q <= 1'b0;
        end else begin
            hdr_len_q   <= hdr_len_d;
            hdr_id_q    <= hdr_id_d;
            cds_count_q <= cds_count_d;
            last_seen_q <= last_seen_d;
            hdr_valid_q <= hdr_valid_d;
            err_trunc_q <= err_trunc_d;
        end
    end

    assign hdr_valid = hdr_valid_q;
    assign hdr_id    = hdr_id_q;
    assign hdr_len   = hdr_len_q;
    assign err_trunc = err_trunc_q;
    assign cds_count = cds_count_q;

endmodule

// File: doc/rice_cds_sequencer.md
RICE_CDS_SEQUENCER -- requirements
Module: rice_cds_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  clock; reset  in  1  reset, asynchronous, active-high.
REQ-002 SHALL have: cfg_n  in  5  sample resolution in bits, sampled at packet start.
REQ-003 SHALL have: s_valid  in  1, s_ready  out  1, s_data  in  32, s_last  in  1 (last word of the packet); this is the upstream packet word stream.
REQ-004 SHALL have: d_valid  out  1, d_ready  in  1, d_data  out  32, d_first  out  1 (first word of a CDS); this is the word stream to the Rice decoder.
REQ-005 SHALL have: dec_done  in  1, a single-cycle pulse from the decoder marking the end of the current CDS.
REQ-006 SHALL have: hdr_valid  out  1; hdr_id  out  5 (option ID, right-justified, zero-extended); hdr_len  out  3.
REQ-007 SHALL have: busy  out  1; err_trunc  out  1 (single-cycle pulse); cds_count  out  16.

Function
REQ-008 SHALL use an FSM with states IDLE, PRI, ID, BODY.
REQ-009 Handshake: a word transfers on a cycle where valid and ready are both high; s_valid and s_data are held until accepted.
REQ-010 Header length from cfg_n: 0..4 -> 2; 5..8 -> 3; 9..16 -> 4; 17..31 -> 5. Latched into hdr_len when leaving IDLE.
REQ-011 IDLE: s_ready=0 and d_valid=0; on s_valid=1, go to PRI next cycle and clear cds_count.
REQ-012 PRI: s_ready=1; d_valid=0; the primary-header word is consumed and dropped; on transfer go to ID.
REQ-013 ID: d_valid=s_valid, s_ready=d_ready, d_first=1, d_data=s_data shifted left by hdr_len with zero fill.
REQ-014 ID: on transfer, latch the top hdr_len bits of s_data into hdr_id, pulse hdr_valid on the following cycle, and go to BODY.
REQ-015 BODY: combinational pass-through; d_valid=s_valid, s_ready=d_ready, d_data=s_data, d_first=0.
REQ-016 BODY: dec_done=1 increments cds_count (saturating at 0xFFFF) and moves to ID, unless an s_last has already transferred in this packet (last_seen flag), in which case it moves to IDLE.
REQ-017 BODY: dec_done on the same cycle as an s_last transfer: the word is forwarded, cds_count is incremented, and the FSM goes to IDLE.
REQ-018 BODY: after an s_last transfer without dec_done, hold s_ready=0 and wait in BODY for dec_done.
REQ-019 An s_last transfer in PRI or ID SHALL pulse err_trunc on the next cycle, return to IDLE, and emit no hdr_valid for that word.
REQ-020 dec_done outside BODY SHALL be ignored.
REQ-021 busy=1 in every state except IDLE.
REQ-022 Changes to cfg_n while busy=1 SHALL have no effect until the next packet.

Reset
REQ-023 Reset asserted SHALL force, immediately: state IDLE; s_ready, d_valid, d_first, hdr_valid, err_trunc, busy = 0; hdr_id, hdr_len, cds_count = 0; last_seen cleared.
REQ-024 Reset mid-packet SHALL abandon the packet with no err_trunc; the first s_valid after deassertion is treated as a new primary-header word.

Structure
REQ-025 The shared package rice_pkg SHALL hold the state enum, the header-length thresholds (4/8/16) and the width constants (word 32, ID 5, count 16).
REQ-026 The n-to-length mapping SHALL live in one combinational sub-module, rice_hdr_len_lut; the FSM, counter and muxes stay in the top module.

Verification
REQ-027 cfg_n=8, words 0xAAAA0000, 0xB1234567, 0x00000001(last); d_ready=1; dec_done pulsed with the last word -> hdr_len=3; hdr_id=5; d_data 0x891A2B38 with d_first=1, then 0x00000001; cds_count=1; FSM back in IDLE.
REQ-028 cfg_n=16, two CDSs, dec_done after each; second ID word 0xF0000000 -> hdr_id=0xF, d_data=0x00000000, cds_count=2.
REQ-029 cfg_n=4, packet of 2 words with s_last on the ID word -> err_trunc pulses once, no hdr_valid, FSM in IDLE.
REQ-030 d_ready held low 5 cycles during BODY -> s_ready low for those cycles, no word lost or duplicated, d_data stable.
REQ-031 s_last transferred, dec_done 3 cycles later -> s_ready=0 while waiting; IDLE on dec_done; cds_count increments by 1.
REQ-032 Reset asserted in BODY -> all outputs zero at once; a new packet afterwards decodes correctly with cds_count restarting at 0.
